// File: rtl/imem_resp.sv
// imem_resp: word-addressed RAM target for the mem_in_type/mem_out_type request protocol.
// Each accepted request is answered by one registered mem_ready pulse after mem_latency wait states.
package imem_resp_pkg;
    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_ready;
    } mem_out_type;
endpackage

module imem_resp
    import imem_resp_pkg::*;
#(
    parameter int unsigned mem_depth   = 4096,
    parameter int unsigned mem_latency = 2,
    parameter logic [31:0] mem_base    = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out
);
    localparam int unsigned AddrW    = $clog2(mem_depth);
    localparam logic [3:0]  WaitInit = (mem_latency == 0) ? 4'd0 : 4'(mem_latency - 1);
    localparam logic [63:0] SpanB    = 64'(mem_depth) * 64'd4;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q;
    logic [3:0]  wait_cnt_q;
    logic        fence_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        ready_q;
    logic [31:0] rdata_q;

    logic [31:0] mem_q [mem_depth];

    logic             accept;
    logic             enter_resp;
    logic             sel_fence;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic [3:0]       sel_wstrb;
    logic [32:0]      diff;
    logic [31:0]      off;
    logic             in_range;
    logic [AddrW-1:0] idx;
    logic             do_read;
    logic             do_write;
    logic             unused_instr;

    assign unused_instr = imem_in.mem_instr;

    always_comb begin
        accept = imem_in.mem_valid && (state_q != StWait);
        if (mem_latency == 0) begin
            // With no wait states the RAM access happens on the accepting edge itself.
            enter_resp = accept;
            sel_fence  = imem_in.mem_fence;
            sel_addr   = imem_in.mem_addr;
            sel_wdata  = imem_in.mem_wdata;
            sel_wstrb  = imem_in.mem_wstrb;
        end else begin
            enter_resp = (state_q == StWait) && (wait_cnt_q == 4'd0);
            sel_fence  = fence_q;
            sel_addr   = addr_q;
            sel_wdata  = wdata_q;
            sel_wstrb  = wstrb_q;
        end
        // Borrow bit flags addresses below mem_base; the offset compare avoids any wrap.
        diff     = {1'b0, sel_addr} - {1'b0, mem_base};
        off      = diff[31:0];
        in_range = !diff[32] && (64'(off) < SpanB);
        idx      = off[AddrW+1:2];
        do_read  = enter_resp && !sel_fence && in_range && (sel_wstrb == 4'd0);
        do_write = enter_resp && reset && !sel_fence && in_range && (sel_wstrb != 4'd0);
    end

    always_ff @(posedge clock) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_wstrb[b]) begin
                    mem_q[idx][8*b +: 8] <= sel_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
            fence_q    <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
            ready_q    <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            ready_q <= 1'b0;
            rdata_q <= 32'h0;
            if (enter_resp) begin
                ready_q <= 1'b1;
                if (do_read) begin
                    rdata_q <= mem_q[idx];
                end
            end
            unique case (state_q)
                StIdle, StResp: begin
                    if (imem_in.mem_valid) begin
                        fence_q    <= imem_in.mem_fence;
                        addr_q     <= imem_in.mem_addr;
                        wdata_q    <= imem_in.mem_wdata;
                        wstrb_q    <= imem_in.mem_wstrb;
                        wait_cnt_q <= WaitInit;
                        state_q    <= (mem_latency == 0) ? StResp : StWait;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_q <= StResp;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign imem_out.mem_ready = ready_q;
    assign imem_out.mem_rdata = rdata_q;
endmodule

// File: tb/tb_imem_resp.sv
// Bench for imem_resp: directed table, hand-written multi-cycle sequences and a randomized
// run against a word-array reference model, on three parameter sets.
module tb_imem_resp;
    import imem_resp_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    mem_in_type  req [3];
    mem_out_type rsp [3];

    int lat_of   [3] = '{2, 0, 3};
    int depth_of [3] = '{64, 64, 32};
    int base_of  [3] = '{32'h0, 32'h0, 32'h100};

    logic [31:0] model [3][64];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    imem_resp #(.mem_depth(64), .mem_latency(2), .mem_base(32'h0)) u_lat2 (
        .clock(clock), .reset(reset), .imem_in(req[0]), .imem_out(rsp[0]));
    imem_resp #(.mem_depth(64), .mem_latency(0), .mem_base(32'h0)) u_lat0 (
        .clock(clock), .reset(reset), .imem_in(req[1]), .imem_out(rsp[1]));
    imem_resp #(.mem_depth(32), .mem_latency(3), .mem_base(32'h100)) u_lat3 (
        .clock(clock), .reset(reset), .imem_in(req[2]), .imem_out(rsp[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Spec-level reference: range test on byte addresses, byte-merge on writes.
    function automatic logic [31:0] model_access(input int d, input logic fence,
                                                 input logic [31:0] addr, input logic [31:0] wdata,
                                                 input logic [3:0] wstrb);
        longint a  = longint'(addr);
        longint lo = longint'(base_of[d]);
        longint hi = lo + 4 * longint'(depth_of[d]);
        int     i;
        if (fence || a < lo || a >= hi) return 32'h0;
        i = int'((a - lo) / 4);
        if (wstrb == 4'h0) return model[d][i];
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) model[d][i][8*b +: 8] = wdata[8*b +: 8];
        end
        return 32'h0;
    endfunction

    // One request: checks latency, rdata, quiet outputs while waiting and a single-cycle pulse.
    task automatic run_req(input int d, input logic fence, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input logic [31:0] exp, input string name);
        int          n = 0;
        bit          got = 0;
        bit          quiet = 1;
        logic [31:0] rd = 32'h0;
        req[d].mem_valid = 1'b1;
        req[d].mem_fence = fence;
        req[d].mem_instr = 1'($urandom_range(0, 1));
        req[d].mem_addr  = addr;
        req[d].mem_wdata = wdata;
        req[d].mem_wstrb = wstrb;
        while (!got && n < 40) begin
            @(posedge clock);
            #1;
            n++;
            if (rsp[d].mem_ready) begin
                got = 1;
                rd  = rsp[d].mem_rdata;
                req[d].mem_valid = 1'b0;
            end else begin
                if (rsp[d].mem_rdata != 32'h0) quiet = 0;
                // Garbage while waiting: the block must work from the latched request.
                req[d].mem_fence = 1'($urandom_range(0, 1));
                req[d].mem_addr  = $urandom;
                req[d].mem_wdata = $urandom;
                req[d].mem_wstrb = 4'($urandom);
            end
        end
        req[d].mem_valid = 1'b0;
        check({name, " latency"}, 32'(n), 32'(lat_of[d] + 1));
        check({name, " rdata"}, rd, exp);
        @(posedge clock);
        #1;
        check({name, " pulse/quiet"}, {30'h0, rsp[d].mem_ready, ~quiet},
              {31'h0, (rsp[d].mem_rdata != 32'h0)});
    endtask

    typedef struct {
        logic        fence;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [16];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) req[d] = '0;

        tbl[0]  = '{1'b0, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0};
        tbl[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 32'h20,  32'h11223344, 4'hF, 32'h0};
        tbl[3]  = '{1'b0, 32'h20,  32'hAABBCCDD, 4'h5, 32'h0};
        tbl[4]  = '{1'b0, 32'h20,  32'h0,        4'h0, 32'h11BB33DD};
        tbl[5]  = '{1'b0, 32'h40,  32'h600DF00D, 4'hF, 32'h0};
        tbl[6]  = '{1'b1, 32'h40,  32'hFFFFFFFF, 4'hF, 32'h0};
        tbl[7]  = '{1'b0, 32'h40,  32'h0,        4'h0, 32'h600DF00D};
        tbl[8]  = '{1'b0, 32'h0,   32'hCAFEF00D, 4'hF, 32'h0};
        tbl[9]  = '{1'b0, 32'h100, 32'h12345678, 4'hF, 32'h0};
        tbl[10] = '{1'b0, 32'h100, 32'h0,        4'h0, 32'h0};
        tbl[11] = '{1'b0, 32'h0,   32'h0,        4'h0, 32'hCAFEF00D};
        tbl[12] = '{1'b0, 32'h30,  32'h00000055, 4'hF, 32'h0};
        tbl[13] = '{1'b0, 32'h13,  32'h0,        4'h0, 32'hDEADBEEF};
        tbl[14] = '{1'b0, 32'hFC,  32'hA5A5A5A5, 4'hF, 32'h0};
        tbl[15] = '{1'b0, 32'hFC,  32'h0,        4'h0, 32'hA5A5A5A5};

        #3 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset dut%0d", d), {rsp[d].mem_rdata[30:0], rsp[d].mem_ready}, 32'h0);
        end
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_req(0, tbl[i].fence, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].exp,
                    $sformatf("tbl%0d", i));
        end

        // Zero-latency back-to-back reads.
        run_req(1, 1'b0, 32'h0, 32'd1, 4'hF, 32'h0, "b2b w0");
        run_req(1, 1'b0, 32'h4, 32'd2, 4'hF, 32'h0, "b2b w1");
        run_req(1, 1'b0, 32'h8, 32'd3, 4'hF, 32'h0, "b2b w2");
        req[1].mem_valid = 1'b1;
        req[1].mem_wstrb = 4'h0;
        req[1].mem_fence = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req[1].mem_addr = 32'(4 * k);
            @(posedge clock);
            #1;
            check($sformatf("b2b ready%0d", k), {31'h0, rsp[1].mem_ready}, 32'h1);
            check($sformatf("b2b rdata%0d", k), rsp[1].mem_rdata, 32'(k + 1));
        end
        req[1].mem_valid = 1'b0;
        @(posedge clock);
        #1;
        check("b2b end", {31'h0, rsp[1].mem_ready}, 32'h0);

        // Reset while a write sits in WAIT: it must be discarded.
        req[0] = '{1'b1, 1'b0, 1'b0, 32'h30, 32'hFFFFFFFF, 4'hF};
        @(posedge clock);
        #1;
        req[0].mem_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rst wait ready", {31'h0, rsp[0].mem_ready}, 32'h0);
        check("rst wait rdata", rsp[0].mem_rdata, 32'h0);
        repeat (3) @(posedge clock);
        #1;
        check("rst hold ready", {31'h0, rsp[0].mem_ready}, 32'h0);
        reset = 1'b1;
        run_req(0, 1'b0, 32'h30, 32'h0, 4'h0, 32'h55, "rst readback");

        // Randomized traffic against the reference model.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < depth_of[d]; i++) begin
                logic [31:0] v = $urandom;
                logic [31:0] a = 32'(base_of[d] + 4 * i);
                run_req(d, 1'b0, a, v, 4'hF, model_access(d, 1'b0, a, v, 4'hF), "init");
            end
            for (int k = 0; k < 150; k++) begin
                int          r     = int'($urandom_range(0, 15));
                logic [31:0] a;
                logic [31:0] v     = $urandom;
                logic [3:0]  s     = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                logic        f     = ($urandom_range(0, 7) == 0);
                logic [31:0] e;
                if (r == 0) a = 32'(base_of[d] + 4 * depth_of[d] + 4 * int'($urandom_range(0, 3)));
                else if (r == 1 && base_of[d] != 0) a = 32'(base_of[d] - 4 * int'($urandom_range(1, 4)));
                else a = 32'(base_of[d] + 4 * int'($urandom_range(0, depth_of[d] - 1)));
                a[1:0] = 2'($urandom_range(0, 3));
                e = model_access(d, f, a, v, s);
                run_req(d, f, a, v, s, e, $sformatf("rand d%0d k%0d a%h", d, k, a));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
